reflet_dma8: RTL and testbench
==============================

Name: reflet_dma8

Overview:
- Memory-mapped 8-bit DMA controller for the 8-bit Reflet controller system bus.
- The CPU programs it through four slave registers.
- It requests the shared bus from an external arbiter, then copies LEN bytes from SRC to DST using a read/capture/write sequence.
- It raises a done interrupt that is wired to one ext_int line.

Parameters:
- base_addr_size, 7, width of the slave address compared against base_addr.
- base_addr, 7'h68, slave offset of register 0; registers occupy base_addr..base_addr+3.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  slave region select (driven from addr[7]).
- addr  in  base_addr_size  slave address.
- data_in  in  8  CPU write data.
- data_out  out  8  slave read data; 0 when not addressed (OR-bus).
- write_en  in  1  CPU write strobe.
- bus_req  out  1  bus request to arbiter.
- bus_gnt  in  1  bus grant from arbiter.
- m_addr  out  8  master address; 0 when not granted.
- m_data_out  out  8  master write data; 0 when not granted.
- m_data_in  in  8  master read data, valid the cycle after the address.
- m_write_en  out  1  master write strobe.
- irq  out  1  done interrupt, level.

Behaviour:
- Registers (offset from base_addr):
  - 0 SRC.
  - 1 DST.
  - 2 LEN.
  - 3 CTRL: bit0 START/BUSY, bit1 IRQ_EN, bit2 DONE, bit3 SRC_FIXED, bit4 DST_FIXED, bit5 ABORT.
- Reset: all registers 0, state IDLE. All outputs 0.
- Slave access:
  - A register is selected when enable=1 and addr = base_addr+offset.
  - data_out is registered, one cycle latency; 0 the cycle after a non-matching address.
  - CTRL read returns BUSY in bit0 and DONE in bit2; bit5 reads 0.
- Register writes while BUSY:
  - Writes to SRC, DST and LEN are ignored.
  - CTRL writes update only IRQ_EN and ABORT (ABORT write-1 sets an internal abort request).
  - START=1 while BUSY is ignored.
- Writing 1 to DONE clears it, in any state.
- START=1 while IDLE:
  - Latches SRC_FIXED and DST_FIXED, clears DONE.
  - LEN=0: no bus request; go straight to DONE next cycle.
  - Otherwise go to REQ.
- State machine:
  - IDLE: bus_req=0.
  - REQ: bus_req=1; wait for bus_gnt=1, then go to RD.
  - RD: m_addr=SRC, m_write_en=0; go to CAP.
  - CAP: m_addr=SRC; capture m_data_in into the internal byte register; go to WR.
  - WR: m_addr=DST, m_data_out=byte, m_write_en=1. Then:
    - SRC+=1 unless SRC_FIXED; DST+=1 unless DST_FIXED; LEN-=1.
    - Go to DONE if the new LEN=0 or an abort is pending, else go to RD.
  - DONE: bus_req=0; set DONE, clear BUSY and the abort request; go to IDLE.
- bus_req stays high from REQ through the last WR cycle inclusive; the bus is held for the whole transfer.
- Master outputs are forced to 0 whenever state is not RD, CAP or WR.
- The arbiter must not drop bus_gnt while bus_req=1. If bus_gnt=0 in RD, CAP or WR, the block pauses in place with master outputs at 0 and resumes the same state when bus_gnt returns.
- Timing: 3 cycles per byte once granted. N bytes take REQ + 3N + DONE.
- Address arithmetic is 8-bit with wrap-around: 0xFF+1=0x00.
- SRC, DST and LEN update live, so readback shows progress. After an abort they show the remaining work.
- irq = DONE & IRQ_EN.
- A reset mid-transfer returns to IDLE with bus_req=0 and m_write_en=0 in the following cycle. The partially copied destination is left as is.

Test Plan:
- Register readback: write SRC=0x90, DST=0xA0, LEN=4, CTRL=0x02, then read each back → values returned exactly, with one-cycle latency; an unmapped address reads 0.
- 4-byte copy: memory 0x90..0x93 = 11,22,33,44; SRC=0x90, DST=0xA0, LEN=4, START, gnt tied high → 0xA0..0xA3 = 11,22,33,44; exactly 4 m_write_en pulses, 3 cycles apart; bus_req high for 13 cycles; SRC=0x94, LEN=0, DONE=1, irq=1; writing CTRL=0x04 clears irq.
- LEN=0 START → bus_req never asserts; DONE=1 two cycles after the START write.
- SRC_FIXED with SRC=0xFC, DST=0xFE, LEN=3 → DST wraps 0xFE, 0xFF, 0x00; all three writes carry the byte at 0xFC.
- Grant delay: hold bus_gnt low for 10 cycles after bus_req rises, then drop it for 2 cycles during CAP → no master activity while ungranted; copy completes correctly.
- ABORT written during byte 2 of LEN=5 → stops after byte 2's write; LEN=3, DONE=1. Reset asserted mid-copy → bus_req=0 next cycle, all registers 0.

Source files
------------

// File: rtl/reflet_dma8.sv
// Single-channel byte-copy DMA for the Reflet 8-bit bus: four slave registers,
// bus request/grant handshake, and a read/capture/write copy loop per byte.
module reflet_dma8 #(
    parameter int                        base_addr_size = 7,
    parameter logic [base_addr_size-1:0] base_addr      = 7'h68
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic                      write_en,
    output logic                      bus_req,
    input  logic                      bus_gnt,
    output logic [7:0]                m_addr,
    output logic [7:0]                m_data_out,
    input  logic [7:0]                m_data_in,
    output logic                      m_write_en,
    output logic                      irq
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_RD, S_CAP, S_WR, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [7:0] src, dst, len, byte_q;
    logic       irq_en, done, src_fixed, dst_fixed, abort_req;
    logic       addr_ok;
    logic       busy;

    logic [base_addr_size-1:0] off;
    logic       hit, wr_reg, wr_ctrl, start;
    logic [1:0] idx;
    logic [7:0] rd_mux;
    logic       unused_data_bits;

    assign off    = addr - base_addr;
    assign hit    = enable && (off[base_addr_size-1:2] == '0);
    assign idx    = off[1:0];
    assign busy   = (state != S_IDLE);
    assign wr_reg = hit && write_en;
    assign wr_ctrl = wr_reg && (idx == 2'd3);
    assign start  = wr_ctrl && data_in[0] && !busy;
    assign irq    = done && irq_en;
    assign unused_data_bits = ^data_in[7:6];

    always_comb begin
        rd_mux = 8'h00;
        case (idx)
            2'd0:    rd_mux = src;
            2'd1:    rd_mux = dst;
            2'd2:    rd_mux = len;
            default: rd_mux = {3'b000, dst_fixed, src_fixed, done, irq_en, busy};
        endcase
    end

    always_comb begin
        state_nx   = state;
        bus_req    = 1'b0;
        m_addr     = 8'h00;
        m_data_out = 8'h00;
        m_write_en = 1'b0;
        case (state)
            S_IDLE: if (start) state_nx = (len == 8'd0) ? S_DONE : S_REQ;
            S_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) state_nx = S_RD;
            end
            S_RD: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    m_addr   = src;
                    state_nx = S_CAP;
                end
            end
            S_CAP: begin
                bus_req = 1'b1;
                // After a pause the read data belongs to whatever address was on
                // the bus meanwhile, so hold one extra cycle to re-present SRC.
                if (bus_gnt) begin
                    m_addr = src;
                    if (addr_ok) state_nx = S_WR;
                end
            end
            S_WR: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    m_addr     = dst;
                    m_data_out = byte_q;
                    m_write_en = 1'b1;
                    state_nx   = (len == 8'd1 || abort_req) ? S_DONE : S_RD;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            data_out  <= 8'h00;
            src       <= 8'h00;
            dst       <= 8'h00;
            len       <= 8'h00;
            byte_q    <= 8'h00;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            src_fixed <= 1'b0;
            dst_fixed <= 1'b0;
            abort_req <= 1'b0;
            addr_ok   <= 1'b0;
        end else begin
            state    <= state_nx;
            data_out <= hit ? rd_mux : 8'h00;
            addr_ok  <= (state == S_RD || state == S_CAP) && bus_gnt;

            if (wr_reg && !busy && idx == 2'd0) src <= data_in;
            if (wr_reg && !busy && idx == 2'd1) dst <= data_in;
            if (wr_reg && !busy && idx == 2'd2) len <= data_in;

            if (wr_ctrl) begin
                irq_en <= data_in[1];
                if (busy) begin
                    if (data_in[5]) abort_req <= 1'b1;
                end else begin
                    src_fixed <= data_in[3];
                    dst_fixed <= data_in[4];
                end
                if (data_in[2] || start) done <= 1'b0;
            end

            if (state == S_CAP && bus_gnt && addr_ok) byte_q <= m_data_in;

            if (state == S_WR && bus_gnt) begin
                src <= src + (src_fixed ? 8'd0 : 8'd1);
                dst <= dst + (dst_fixed ? 8'd0 : 8'd1);
                len <= len - 8'd1;
            end

            // Completion wins over a same-cycle DONE clear from the CPU.
            if (state == S_DONE) begin
                done      <= 1'b1;
                abort_req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reflet_dma8.sv
// Bench for reflet_dma8: register table, directed copy corner cases, and
// randomized copies checked against a plain byte-copy reference model.
module tb_reflet_dma8;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [6:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       write_en;
    logic       bus_req;
    logic       bus_gnt;
    logic [7:0] m_addr;
    logic [7:0] m_data_out;
    logic [7:0] m_data_in;
    logic       m_write_en;
    logic       irq;

    logic       gnt_man, gnt_rnd, rand_mode;
    assign bus_gnt = rand_mode ? gnt_rnd : gnt_man;

    reflet_dma8 dut (
        .clk(clk), .reset(reset), .enable(enable), .addr(addr),
        .data_in(data_in), .data_out(data_out), .write_en(write_en),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .m_addr(m_addr),
        .m_data_out(m_data_out), .m_data_in(m_data_in),
        .m_write_en(m_write_en), .irq(irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cnt, breq_cnt, ungnt_act;
    int wr_cyc [16];
    logic [7:0] wr_adr [16];
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    // Synchronous memory: read data appears the cycle after the address.
    always @(posedge clk) begin
        cyc++;
        m_data_in <= mem[m_addr];
        if (m_write_en) mem[m_addr] <= m_data_out;
    end

    always @(negedge clk) gnt_rnd = ($urandom_range(0, 3) != 0);

    always @(negedge clk) begin
        #2;
        if (m_write_en) begin
            if (wr_cnt < 16) begin
                wr_cyc[wr_cnt] = cyc;
                wr_adr[wr_cnt] = m_addr;
            end
            wr_cnt++;
        end
        if (bus_req) breq_cnt++;
        if (!bus_gnt && (m_addr != 8'h00 || m_data_out != 8'h00 || m_write_en)) ungnt_act++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; addr = a; data_in = d; write_en = 1'b1;
        @(negedge clk);
        enable = 1'b0; addr = 7'h00; data_in = 8'h00; write_en = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a, output logic [7:0] d);
        @(negedge clk);
        enable = 1'b1; addr = a; write_en = 1'b0;
        @(negedge clk);
        enable = 1'b0; addr = 7'h00;
        d = data_out;
    endtask

    task automatic rd_chk(input string nm, input logic [6:0] a, input logic [7:0] e);
        logic [7:0] v;
        rd(a, v);
        chk(nm, v, e);
    endtask

    task automatic wait_idle();
        logic [7:0] v;
        int n = 0;
        do begin
            rd(7'h6B, v);
            n++;
        end while (v[0] && n < 300);
        chk("idle_timeout", v[0], 0);
    endtask

    task automatic wait_wr(input int k);
        int n = 0;
        while (wr_cnt < k && n < 200) begin
            @(negedge clk); #3;
            n++;
        end
        chk("wr_wait_timeout", int'(wr_cnt >= k), 1);
    endtask

    task automatic clr_mon();
        wr_cnt = 0; breq_cnt = 0; ungnt_act = 0;
    endtask

    typedef struct {
        logic [6:0] a;
        logic       w;
        logic [7:0] d;
        logic [7:0] e;
    } vec_t;
    vec_t tv [6];

    initial begin
        logic [7:0] v, b;
        int errs, n;
        reset = 1'b1; enable = 1'b0; addr = 7'h00; data_in = 8'h00; write_en = 1'b0;
        gnt_man = 1'b1; rand_mode = 1'b0;
        clr_mon();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_bus_req", bus_req, 0);
        chk("rst_irq", irq, 0);
        chk("rst_m_we", m_write_en, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_data_out", data_out, 0);
        rd_chk("rst_src", 7'h68, 8'h00);
        rd_chk("rst_ctrl", 7'h6B, 8'h00);

        // Register readback table
        tv[0] = '{7'h68, 1'b1, 8'h90, 8'h90};
        tv[1] = '{7'h69, 1'b1, 8'hA0, 8'hA0};
        tv[2] = '{7'h6A, 1'b1, 8'h04, 8'h04};
        tv[3] = '{7'h6B, 1'b1, 8'h02, 8'h02};
        tv[4] = '{7'h6C, 1'b0, 8'h00, 8'h00};
        tv[5] = '{7'h10, 1'b0, 8'h00, 8'h00};
        for (int i = 0; i < 6; i++) begin
            if (tv[i].w) wr(tv[i].a, tv[i].d);
            rd(tv[i].a, v);
            chk($sformatf("regtab%0d", i), v, tv[i].e);
        end

        // 4-byte copy, grant tied high
        mem[8'h90] = 8'h11; mem[8'h91] = 8'h22; mem[8'h92] = 8'h33; mem[8'h93] = 8'h44;
        clr_mon();
        wr(7'h6B, 8'h03);
        wait_idle();
        chk("c4_mem0", mem[8'hA0], 8'h11);
        chk("c4_mem1", mem[8'hA1], 8'h22);
        chk("c4_mem2", mem[8'hA2], 8'h33);
        chk("c4_mem3", mem[8'hA3], 8'h44);
        chk("c4_wr_cnt", wr_cnt, 4);
        for (int i = 1; i < 4; i++) chk($sformatf("c4_gap%0d", i), wr_cyc[i] - wr_cyc[i-1], 3);
        chk("c4_breq_cycles", breq_cnt, 13);
        rd_chk("c4_src", 7'h68, 8'h94);
        rd_chk("c4_dst", 7'h69, 8'hA4);
        rd_chk("c4_len", 7'h6A, 8'h00);
        rd_chk("c4_ctrl", 7'h6B, 8'h06);
        chk("c4_irq", irq, 1);
        wr(7'h6B, 8'h04);
        chk("c4_irq_clr", irq, 0);
        rd_chk("c4_ctrl_clr", 7'h6B, 8'h00);

        // LEN=0 start
        wr(7'h6A, 8'h00);
        clr_mon();
        wr(7'h6B, 8'h03);
        chk("len0_irq_early", irq, 0);
        @(negedge clk);
        chk("len0_irq", irq, 1);
        repeat (4) @(negedge clk);
        chk("len0_no_breq", breq_cnt, 0);
        rd_chk("len0_ctrl", 7'h6B, 8'h06);

        // SRC_FIXED with DST wrap
        b = 8'($urandom_range(1, 255));
        mem[8'hFC] = b; mem[8'hFE] = 8'h00; mem[8'hFF] = 8'h00; mem[8'h00] = 8'h00;
        wr(7'h68, 8'hFC); wr(7'h69, 8'hFE); wr(7'h6A, 8'h03);
        clr_mon();
        wr(7'h6B, 8'h0B);
        wait_idle();
        chk("fix_adr0", wr_adr[0], 8'hFE);
        chk("fix_adr1", wr_adr[1], 8'hFF);
        chk("fix_adr2", wr_adr[2], 8'h00);
        chk("fix_mem_fe", mem[8'hFE], b);
        chk("fix_mem_ff", mem[8'hFF], b);
        chk("fix_mem_00", mem[8'h00], b);
        rd_chk("fix_src", 7'h68, 8'hFC);
        rd_chk("fix_dst", 7'h69, 8'h01);

        // Grant delay then pause during CAP
        for (int i = 0; i < 4; i++) begin
            mem[8'h30 + i] = 8'($urandom);
            mem[8'h40 + i] = 8'h00;
        end
        gnt_man = 1'b0;
        wr(7'h68, 8'h30); wr(7'h69, 8'h40); wr(7'h6A, 8'h04);
        clr_mon();
        wr(7'h6B, 8'h03);
        n = 0;
        while (!bus_req && n < 20) begin @(negedge clk); #3; n++; end
        chk("gd_breq_rise", bus_req, 1);
        repeat (10) @(negedge clk);
        chk("gd_no_wr_ungnt", wr_cnt, 0);
        chk("gd_breq_held", bus_req, 1);
        gnt_man = 1'b1;
        n = 0;
        while (m_addr != 8'h30 && n < 20) begin @(negedge clk); #3; n++; end
        chk("gd_rd_seen", m_addr, 8'h30);
        @(negedge clk);
        gnt_man = 1'b0;
        repeat (2) @(negedge clk);
        gnt_man = 1'b1;
        wait_idle();
        for (int i = 0; i < 4; i++) chk($sformatf("gd_mem%0d", i), mem[8'h40 + i], mem[8'h30 + i]);
        chk("gd_ungnt_act", ungnt_act, 0);
        chk("gd_wr_cnt", wr_cnt, 4);

        // Abort during byte 2 of 5
        for (int i = 0; i < 5; i++) begin
            mem[8'h50 + i] = 8'($urandom_range(1, 255));
            mem[8'h60 + i] = 8'h00;
        end
        wr(7'h68, 8'h50); wr(7'h69, 8'h60); wr(7'h6A, 8'h05);
        clr_mon();
        wr(7'h6B, 8'h03);
        wait_wr(1);
        wr(7'h6B, 8'h22);
        wait_idle();
        chk("ab_wr_cnt", wr_cnt, 2);
        chk("ab_mem0", mem[8'h60], mem[8'h50]);
        chk("ab_mem1", mem[8'h61], mem[8'h51]);
        chk("ab_mem2", mem[8'h62], 8'h00);
        rd_chk("ab_len", 7'h6A, 8'h03);
        rd_chk("ab_src", 7'h68, 8'h52);
        rd_chk("ab_ctrl", 7'h6B, 8'h06);

        // Reset mid-copy
        wr(7'h68, 8'h50); wr(7'h69, 8'h70); wr(7'h6A, 8'h08);
        clr_mon();
        wr(7'h6B, 8'h03);
        wait_wr(2);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #3;
        chk("rm_bus_req", bus_req, 0);
        chk("rm_m_we", m_write_en, 0);
        chk("rm_irq", irq, 0);
        reset = 1'b0;
        rd_chk("rm_src", 7'h68, 8'h00);
        rd_chk("rm_dst", 7'h69, 8'h00);
        rd_chk("rm_len", 7'h6A, 8'h00);
        rd_chk("rm_ctrl", 7'h6B, 8'h00);

        // Randomized copies with a randomly stalling arbiter
        for (int t = 0; t < 20; t++) begin
            logic [7:0] s, d, l, es, ed;
            logic sf, df;
            s  = 8'($urandom); d = 8'($urandom);
            l  = 8'($urandom_range(1, 12));
            sf = 1'($urandom); df = 1'($urandom);
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                ref_mem[i] = mem[i];
            end
            es = s; ed = d;
            for (int i = 0; i < l; i++) begin
                ref_mem[ed] = ref_mem[es];
                if (!sf) es = es + 8'd1;
                if (!df) ed = ed + 8'd1;
            end
            rand_mode = 1'b0;
            wr(7'h68, s); wr(7'h69, d); wr(7'h6A, l);
            clr_mon();
            rand_mode = 1'b1;
            wr(7'h6B, {3'b000, df, sf, 3'b011});
            wait_idle();
            rand_mode = 1'b0;
            errs = 0;
            for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) errs++;
            chk($sformatf("rnd%0d_mem_errs", t), errs, 0);
            chk($sformatf("rnd%0d_wr_cnt", t), wr_cnt, l);
            chk($sformatf("rnd%0d_ungnt", t), ungnt_act, 0);
            rd_chk($sformatf("rnd%0d_src", t), 7'h68, es);
            rd_chk($sformatf("rnd%0d_dst", t), 7'h69, ed);
            rd_chk($sformatf("rnd%0d_ctrl", t), 7'h6B, {3'b000, df, sf, 3'b110});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
